// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the unified memory port: access state encoding,
// default abort limit and the word-alignment helper.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   localparam int TIMEOUT_CYC_DEFAULT = 15;

   function automatic logic word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for an in-flight request; expired is high on the
// LIMIT-th consecutive wait cycle (only used in MEM_TIMEOUT_EN builds).
module mem_wait_counter #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [3:0] count_r;

   // Counts request cycles; held at zero whenever no request is pending.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_r <= 4'd0;
      end else if (clear) begin
         count_r <= 4'd0;
      end else if (enable) begin
         count_r <= count_r + 4'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = enable && (count_r == 4'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Unified instruction/data memory port with req/ready handshake, IR and MDR.
// Optional abort of stuck requests is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [XLEN-1:0]   store_data,
   input  logic              IorD,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              IRWrite,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ready,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic [XLEN-1:0]   inst_reg,
   output logic [XLEN-1:0]   mdr,
   output logic              mem_busy,
   output logic              mem_done,
   output logic              access_err
);

   mem_state_t        state_r, state_next_s;
   logic              dest_ir_r;
   logic              start_s, err_s, timeout_s;
   logic [ADDR_W-1:0] sel_addr_s;

   assign sel_addr_s = IorD ? alu_out : pc;
   assign mem_busy   = (state_r == MEM_REQ);

`ifdef MEM_TIMEOUT_EN
   mem_wait_counter #(
      .LIMIT(TIMEOUT_CYC)
   ) u_wait_counter (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (state_r != MEM_REQ),
      .enable (mem_busy),
      .expired(timeout_s)
   );
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state decode; a command with both strobes or a misaligned address is flagged, not issued.
   always_comb begin
      state_next_s = state_r;
      start_s      = 1'b0;
      err_s        = 1'b0;
      case (state_r)
         MEM_IDLE: begin
            if (MemRead ^ MemWrite) begin
               if (word_aligned(sel_addr_s[1:0])) begin
                  start_s      = 1'b1;
                  state_next_s = MEM_REQ;
               end else begin
                  err_s = 1'b1;
               end
            end else if (MemRead & MemWrite) begin
               err_s = 1'b1;
            end else begin
               state_next_s = MEM_IDLE;
            end
         end
         MEM_REQ: begin
            if (mem_ready) begin
               state_next_s = MEM_DONE;
            end else if (timeout_s) begin
               err_s        = 1'b1;
               state_next_s = MEM_IDLE;
            end else begin
               state_next_s = MEM_REQ;
            end
         end
         MEM_DONE: state_next_s = MEM_IDLE;
         default:  state_next_s = MEM_IDLE;
      endcase
   end

   // State, handshake outputs and the IR/MDR capture registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= MEM_IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_done   <= 1'b0;
         access_err <= 1'b0;
         inst_reg   <= '0;
         mdr        <= '0;
         dest_ir_r  <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         mem_req  <= (state_next_s == MEM_REQ);
         mem_done <= (state_r == MEM_REQ) && mem_ready;
         if (start_s) begin
            mem_addr  <= sel_addr_s;
            mem_wdata <= store_data;
            mem_we    <= MemWrite;
            dest_ir_r <= IRWrite;
         end
         if ((state_r == MEM_REQ) && mem_ready && !mem_we) begin
            if (dest_ir_r) begin
               inst_reg <= mem_rdata;
            end else begin
               mdr <= mem_rdata;
            end
         end
         if (err_s) begin
            access_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (fetch, load, store,
// error, reset, and timeout or indefinite wait depending on MEM_TIMEOUT_EN).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc, alu_out, store_data, mem_rdata;
   logic        IorD, MemRead, MemWrite, IRWrite, mem_ready;
   logic        mem_req, mem_we, mem_busy, mem_done, access_err;
   logic [31:0] mem_addr, mem_wdata, inst_reg, mdr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .reset_n(reset_n), .pc(pc), .alu_out(alu_out),
      .store_data(store_data), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .inst_reg(inst_reg),
      .mdr(mdr), .mem_busy(mem_busy), .mem_done(mem_done),
      .access_err(access_err)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cmd();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_value({tag, "_req"}, 32'(mem_req), 32'd0);
      check_value({tag, "_we"}, 32'(mem_we), 32'd0);
      check_value({tag, "_addr"}, mem_addr, 32'd0);
      check_value({tag, "_wdata"}, mem_wdata, 32'd0);
      check_value({tag, "_ir"}, inst_reg, 32'd0);
      check_value({tag, "_mdr"}, mdr, 32'd0);
      check_value({tag, "_busy"}, 32'(mem_busy), 32'd0);
      check_value({tag, "_done"}, 32'(mem_done), 32'd0);
      check_value({tag, "_err"}, 32'(access_err), 32'd0);
   endtask

   initial begin
      int req_cycles;
      int done_seen;
      reset_n = 1'b0; pc = 32'd0; alu_out = 32'd0; store_data = 32'd0;
      mem_rdata = 32'd0; IorD = 1'b0; mem_ready = 1'b0;
      idle_cmd();
      tick(); tick();
      check_all_zero("reset");
      reset_n = 1'b1;

      // Fetch: ready at cycle 3
      pc = 32'h10; IorD = 1'b0; MemRead = 1'b1; IRWrite = 1'b1;
      tick();
      idle_cmd();
      check_value("fetch_req", 32'(mem_req), 32'd1);
      check_value("fetch_busy", 32'(mem_busy), 32'd1);
      check_value("fetch_addr", mem_addr, 32'h10);
      check_value("fetch_we", 32'(mem_we), 32'd0);
      tick(); tick();
      check_value("fetch_wait_req", 32'(mem_req), 32'd1);
      check_value("fetch_wait_done", 32'(mem_done), 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'h00A00093;
      tick();
      mem_ready = 1'b0;
      check_value("fetch_ir", inst_reg, 32'h00A00093);
      check_value("fetch_done", 32'(mem_done), 32'd1);
      check_value("fetch_mdr", mdr, 32'd0);
      check_value("fetch_done_busy", 32'(mem_busy), 32'd0);
      check_value("fetch_done_req", 32'(mem_req), 32'd0);
      tick();
      check_value("fetch_done_pulse", 32'(mem_done), 32'd0);

      // Load: ready the cycle after the request appears
      alu_out = 32'h104; IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b0;
      tick();
      idle_cmd();
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ready = 1'b0;
      check_value("load_mdr", mdr, 32'hDEADBEEF);
      check_value("load_addr", mem_addr, 32'h104);
      check_value("load_ir", inst_reg, 32'h00A00093);
      check_value("load_done", 32'(mem_done), 32'd1);
      // Command presented during DONE must be ignored
      pc = 32'h20; IorD = 1'b0; MemRead = 1'b1;
      tick();
      idle_cmd();
      check_value("done_ignore_req", 32'(mem_req), 32'd0);
      check_value("done_ignore_addr", mem_addr, 32'h104);
      // Stray ready while idle must be ignored
      mem_ready = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ready = 1'b0;
      check_value("stray_ready_mdr", mdr, 32'hDEADBEEF);
      check_value("stray_ready_done", 32'(mem_done), 32'd0);

      // Store: ready at cycle 2
      alu_out = 32'h200; IorD = 1'b1; MemWrite = 1'b1; store_data = 32'h55AA;
      tick();
      idle_cmd();
      store_data = 32'h0;
      check_value("store_we1", 32'(mem_we), 32'd1);
      check_value("store_wdata", mem_wdata, 32'h55AA);
      check_value("store_addr", mem_addr, 32'h200);
      tick();
      check_value("store_we2", 32'(mem_we), 32'd1);
      check_value("store_req2", 32'(mem_req), 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ready = 1'b0;
      check_value("store_done", 32'(mem_done), 32'd1);
      check_value("store_ir", inst_reg, 32'h00A00093);
      check_value("store_mdr", mdr, 32'hDEADBEEF);
      tick();

      // Both strobes
      check_value("pre_err", 32'(access_err), 32'd0);
      pc = 32'h30; IorD = 1'b0; MemRead = 1'b1; MemWrite = 1'b1;
      tick();
      check_value("both_err", 32'(access_err), 32'd1);
      check_value("both_req", 32'(mem_req), 32'd0);
      tick();
      idle_cmd();
      check_value("both_req2", 32'(mem_req), 32'd0);
      check_value("both_sticky", 32'(access_err), 32'd1);

      // Misaligned load, from a fresh reset
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_value("rst_clears_err", 32'(access_err), 32'd0);
      alu_out = 32'h102; IorD = 1'b1; MemRead = 1'b1;
      tick();
      idle_cmd();
      check_value("misalign_err", 32'(access_err), 32'd1);
      check_value("misalign_req", 32'(mem_req), 32'd0);
      check_value("misalign_addr", mem_addr, 32'd0);

      // Reset during REQ
      alu_out = 32'h300; IorD = 1'b1; MemRead = 1'b1;
      tick();
      idle_cmd();
      check_value("pre_rst_req", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_all_zero("midreq_rst");

      // Stuck request: abort after 15 cycles, or wait indefinitely
      alu_out = 32'h400; IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b0;
      tick();
      idle_cmd();
      req_cycles = 0;
      done_seen = 0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 40 && mem_req; i++) begin
         req_cycles++;
         tick();
         if (mem_done) done_seen = 1;
      end
      check_value("timeout_cycles", 32'(req_cycles), 32'd15);
      check_value("timeout_req", 32'(mem_req), 32'd0);
      check_value("timeout_err", 32'(access_err), 32'd1);
      check_value("timeout_no_done", 32'(done_seen), 32'd0);
      check_value("timeout_mdr", mdr, 32'd0);
`else
      for (int i = 0; i < 20; i++) begin
         if (mem_req) req_cycles++;
         if (mem_done) done_seen = 1;
         tick();
      end
      check_value("wait_cycles", 32'(req_cycles), 32'd20);
      check_value("wait_req", 32'(mem_req), 32'd1);
      check_value("wait_err", 32'(access_err), 32'd0);
      check_value("wait_no_done", 32'(done_seen), 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_ready = 1'b0;
      check_value("wait_done", 32'(mem_done), 32'd1);
      check_value("wait_mdr", mdr, 32'h0BADF00D);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
